// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch-stage PC owner feeding a small prefetch FIFO to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int          DEPTH          = 2,
  parameter bit          USE_START_ADDR = 1'b1,
  parameter logic [31:0] RESET_PC       = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] read_address,
  input  logic [31:0] mem_instruction,
  input  logic [31:0] start_addr,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        fault_misaligned
);

  localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_pc;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 r_fault;
  logic [31:0]          r_fifo_instr [DEPTH];
  logic [31:0]          r_fifo_pc    [DEPTH];

  logic                 w_run;
  logic                 w_redirect;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_not_empty;
  logic [31:0]          w_boot_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_redirect  = w_run && redirect_valid;
  assign w_not_empty = (r_count != '0);
  assign w_boot_pc   = (USE_START_ADDR ? start_addr : RESET_PC) & ~32'h3;

  // Redirect voids the handshake, so it masks valid before pop is formed.
  assign out_valid   = w_not_empty && !redirect_valid;
  assign w_pop       = out_valid && out_ready;
  assign w_push      = w_run && fetch_enable && !redirect_valid &&
                       ((r_count < c_depth) || w_pop);

  assign read_address     = w_run ? r_pc : 32'h0;
  assign out_instruction  = w_not_empty ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign out_pc           = w_not_empty ? r_fifo_pc[r_rd_ptr]    : 32'h0;
  assign fault_misaligned = r_fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc     <= 32'h0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fault  <= 1'b0;
    end else if (!w_run) begin
      r_pc <= w_boot_pc;
    end else if (w_redirect) begin
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_fault <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked solely by r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= mem_instruction;
      r_fifo_pc[r_wr_ptr]    <= r_pc;
    end
  end

endmodule
`default_nettype wire
